// File: rtl/esa32_seq_adder.sv
// Sequential equal-segmentation approximate adder: one SEG_WIDTH slice per clock, LSB first.
// Define ESA_CARRY_SPEC_EN to speculate each segment carry-in from the previous segment's MSB generate.
module esa32_seq_adder #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned SEG_WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] input1_i,
    input  logic [WIDTH-1:0] input2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    localparam int unsigned NSEG  = WIDTH / SEG_WIDTH;
    localparam int unsigned CNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;

    if ((WIDTH % SEG_WIDTH) != 0) begin : g_bad_seg
        $error("esa32_seq_adder: WIDTH must be an integer multiple of SEG_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;

    logic [NSEG-1:0]    cin_vec;
    logic [SEG_WIDTH-1:0] a_seg, b_seg;
    logic               cin;
    logic [SEG_WIDTH:0] seg_sum;

    assign cin_vec[0] = 1'b0;
    for (genvar g = 1; g < NSEG; g++) begin : g_cin
`ifdef ESA_CARRY_SPEC_EN
        assign cin_vec[g] = a_q[g*SEG_WIDTH-1] & b_q[g*SEG_WIDTH-1];
`else
        assign cin_vec[g] = 1'b0;
`endif
    end

    always_comb begin
        a_seg = '0;
        b_seg = '0;
        cin   = 1'b0;
        for (int unsigned k = 0; k < NSEG; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                a_seg = a_q[k*SEG_WIDTH +: SEG_WIDTH];
                b_seg = b_q[k*SEG_WIDTH +: SEG_WIDTH];
                cin   = cin_vec[k];
            end
        end
        seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + (SEG_WIDTH+1)'(cin);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    a_d     = input1_i;
                    b_d     = input2_i;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned k = 0; k < NSEG; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        sum_d[k*SEG_WIDTH +: SEG_WIDTH] = seg_sum[SEG_WIDTH-1:0];
                    end
                end
                if (cnt_q == CNT_W'(NSEG-1)) begin
                    carry_d = seg_sum[SEG_WIDTH];
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    // Handshake flags are pure state decodes, so no input reaches an output combinationally.
    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign sum_o   = sum_q;
    assign carry_o = carry_q;

endmodule

// File: tb/tb_esa32_seq_adder.sv
// Scoreboard bench for esa32_seq_adder (default 32/8 configuration, either ESA_CARRY_SPEC_EN build).
module tb_esa32_seq_adder;

    localparam int unsigned NSEG = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] input1_i;
    logic [31:0] input2_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] sum_o;
    logic        carry_o;

    typedef struct {
        logic [31:0] s;
        logic        c;
    } exp_t;

    exp_t sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    esa32_seq_adder #(.WIDTH(32), .SEG_WIDTH(8)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .input1_i (input1_i),
        .input2_i (input2_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .sum_o    (sum_o),
        .carry_o  (carry_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t esa_model(input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        logic [8:0] t;
        logic       ci;
        r.s = '0;
        r.c = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ci = 1'b0;
`ifdef ESA_CARRY_SPEC_EN
            if (k > 0) ci = a[8*k-1] & b[8*k-1];
`endif
            t = {1'b0, a[8*k +: 8]} + {1'b0, b[8*k +: 8]} + {8'd0, ci};
            r.s[8*k +: 8] = t[7:0];
            if (k == 3) r.c = t[8];
        end
        return r;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] es, input logic ec, input int unsigned hold);
        int unsigned n;
        exp_t e;
        check("ready_idle", ready_o, 1);
        input1_i = a;
        input2_i = b;
        valid_i  = 1'b1;
        ready_i  = (hold == 0);
        sb.push_back('{s: es, c: ec});
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        check("ready_run", ready_o, 0);
        n = 0;
        while (!valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, NSEG);
        check("sb_size", sb.size(), 1);
        e = sb.pop_front();
        check("sum", sum_o, e.s);
        check("carry", carry_o, e.c);
        for (int unsigned i = 0; i < hold; i++) begin
            valid_i  = 1'b1;
            input1_i = $urandom;
            @(negedge clk);
            check("bp_valid", valid_o, 1);
            check("bp_ready", ready_o, 0);
            check("bp_sum", sum_o, e.s);
            check("bp_carry", carry_o, e.c);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        check("rel_valid", valid_o, 0);
        check("rel_ready", ready_o, 1);
        check("held_sum", sum_o, e.s);
        check("held_carry", carry_o, e.c);
    endtask

    initial begin
        exp_t m;
        logic [31:0] ra, rb;
        int unsigned n;

        rst_i    = 1'b1;
        valid_i  = 1'b1;
        ready_i  = 1'b1;
        input1_i = 32'hDEAD_BEEF;
        input2_i = 32'h1234_5678;
        repeat (3) @(negedge clk);
        rst_i   = 1'b0;
        valid_i = 1'b0;
        check("rst_ready", ready_o, 1);
        check("rst_valid", valid_o, 0);
        check("rst_sum", sum_o, 0);
        check("rst_carry", carry_o, 0);
        @(negedge clk);
        check("no_accept_in_rst", ready_o, 1);

        run_op(32'h1234_5678, 32'h0101_0101, 32'h1335_5779, 1'b0, 0);
`ifdef ESA_CARRY_SPEC_EN
        run_op(32'h0000_0080, 32'h0000_0080, 32'h0000_0100, 1'b0, 0);
`else
        run_op(32'h0000_0080, 32'h0000_0080, 32'h0000_0000, 1'b0, 0);
`endif
        run_op(32'h0000_00FF, 32'h0000_0001, 32'h0000_0000, 1'b0, 0);
        run_op(32'hFF00_0000, 32'h0100_0000, 32'h0000_0000, 1'b1, 0);
        run_op(32'h1234_5678, 32'h0101_0101, 32'h1335_5779, 1'b0, 5);

        // Reset during the second RUN cycle discards the operation.
        input1_i = 32'h1234_5678;
        input2_i = 32'h0101_0101;
        valid_i  = 1'b1;
        sb.push_back('{s: 32'h1335_5779, c: 1'b0});
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        sb.delete();
        check("mid_rst_ready", ready_o, 1);
        check("mid_rst_sum", sum_o, 0);
        check("mid_rst_carry", carry_o, 0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (valid_o) n++;
            @(negedge clk);
        end
        check("mid_rst_no_valid", n, 0);
        run_op(32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) begin ra = 32'h8080_8080; rb = 32'h8080_8080; end
            if (i == 1) begin ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF; end
            m = esa_model(ra, rb);
            run_op(ra, rb, m.s, m.c, (i % 3 == 2) ? 2 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got stuck expected finish");
        $fatal(1);
    end

endmodule

// File: doc/esa32_seq_adder.md
Name: esa32_seq_adder

Overview:
- Multi-cycle equal-segmentation approximate adder (ESA). It accepts two WIDTH-bit operands over a valid/ready handshake.
- It computes one SEG_WIDTH-bit segment per clock, LSB segment first, and presents the approximate sum on a valid/ready output port.
- It sits directly downstream of the bit-level half/full adder cells. Each segment's carry-in is derived from those cells' generate (carry) term instead of the true ripple carry.
- It is the sequential, area-reduced counterpart of the combinational 32-bit ESA, intended for error/area characterisation.

Parameters:
- WIDTH, 32, operand and sum width.
- SEG_WIDTH, 8, segment width. WIDTH must be an integer multiple of SEG_WIDTH; violation is an elaboration error.
- NSEG (localparam), WIDTH/SEG_WIDTH, number of segments = compute cycles.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous reset, active-high.
- valid_i  input  1  operands valid.
- ready_o  output  1  block can accept operands.
- input1_i  input  WIDTH  operand A.
- input2_i  input  WIDTH  operand B.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts result.
- sum_o  output  WIDTH  approximate sum.
- carry_o  output  1  carry-out of the top segment.

Behaviour:
- Reset: rst_i sampled high at a rising edge forces state=IDLE, seg_cnt=0, sum_o=0, carry_o=0, valid_o=0, ready_o=1, and clears the operand registers. Reset has priority over every other event, including mid-RUN and in DONE with ready_i high. An in-flight operation is discarded and no valid_o pulse results.
- FSM states: IDLE, RUN, DONE. All outputs are registered or decoded from state only. There are no combinational input-to-output paths.
- IDLE:
  - ready_o=1, valid_o=0.
  - valid_i&&ready_o at an edge captures input1_i/input2_i, clears the sum register, sets seg_cnt=0 and moves to RUN.
- RUN:
  - ready_o=0.
  - Each cycle computes segment k=seg_cnt: {co,s} = A[k] + B[k] + cin_k, where A[k] is bits [k*SEG_WIDTH +: SEG_WIDTH]. s is written into those bits of the sum register. Other bits are untouched.
  - cin_0 = 0 always. For k>0, cin_k = 0 (macro off, pure ESA).
  - On k=NSEG-1, co is written to carry_o, state goes to DONE and seg_cnt resets to 0. Otherwise seg_cnt increments.
  - Input valid_i is ignored in RUN.
- DONE:
  - valid_o=1. sum_o and carry_o are held stable.
  - If ready_i is high at an edge: valid_o=0 next cycle, state goes to IDLE and ready_o=1 next cycle. There is no same-cycle re-accept.
  - If ready_i is low, the block holds indefinitely.
- Latency: operands accepted at edge t give valid_o=1 after edge t+NSEG (NSEG=4 by default). Throughput is at most one operation per NSEG+2 cycles with ready_i tied high.
- sum_o/carry_o change only during RUN or reset. The previous result stays visible in IDLE.
- Arithmetic per segment is unsigned modulo 2^SEG_WIDTH. Carries are never propagated between segments except via the optional feature.
- SEG_WIDTH=WIDTH (NSEG=1) is legal: one RUN cycle, result exact.

Optional Feature:
- Macro ESA_CARRY_SPEC_EN.
- Defined: for k>0, cin_k = A[k*SEG_WIDTH-1] & B[k*SEG_WIDTH-1]. This is the half-adder generate of the previous segment's MSB pair, computed from the captured operands. cin_0 stays 0. Timing and handshake are unchanged.
- Undefined: all cin_k = 0.

Test Plan:
- Reset, then idle: after reset ready_o=1, valid_o=0, sum_o=0, carry_o=0. A valid_i pulse with rst_i high is not accepted.
- Exact case: A=0x12345678, B=0x01010101, ready_i=1 -> valid_o high exactly 4 cycles after accept, sum_o=0x13355779, carry_o=0. Returns to IDLE with ready_o=1 the next cycle.
- Segment carry loss: A=0x00000080, B=0x00000080 -> macro off: sum_o=0x00000000. Macro on: sum_o=0x00000100. A=0x000000FF, B=0x00000001 -> sum_o=0x00000000 in both builds.
- Top carry: A=0xFF000000, B=0x01000000 -> sum_o=0x00000000, carry_o=1.
- Backpressure: hold ready_i=0 for 5 cycles in DONE -> valid_o, sum_o and carry_o are stable and ready_o=0. valid_i pulses in that window are ignored. The result is released on the first ready_i=1 edge.
- Reset mid-operation: assert rst_i at RUN cycle 2 -> next cycle state IDLE, sum_o=0, no valid_o. A subsequent operation (A=0x00000001, B=0x00000002) gives sum_o=0x00000003.
